// File: rtl/imem_pkg.sv
// imem_pkg: shared constants for the instruction-memory responder.
//   - responder FSM state encoding
//   - default word returned on an erroneous fetch
//   - helper that sizes the word-index field from the store depth
package imem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Canonical RISC-V NOP (addi x0, x0, 0).
  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0013;

  localparam int unsigned IMEM_CNT_W = 4;

  // Width of the word index addressing a store of 'depth' words.
  function automatic int unsigned imem_idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x IWIDTH instruction store.
//   i_clk        clock
//   i_rst        synchronous active-low reset (read register only; array untouched)
//   i_we/i_widx/i_wdata  single write port, already range-qualified by the caller
//   i_re/i_ridx  read capture strobe and word index
//   i_rnop       replace the captured word with NOP_WORD (erroneous access)
//   o_rdata      registered read data, holds between captures
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned       IWIDTH   = 32,
  parameter int unsigned       DEPTH    = 1024,
  parameter int unsigned       IDXW     = 10,
  parameter logic [IWIDTH-1:0] NOP_WORD = IWIDTH'(IMEM_NOP_WORD)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [IDXW-1:0]   i_widx,
  input  logic [IWIDTH-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDXW-1:0]   i_ridx,
  input  logic              i_rnop,
  output logic [IWIDTH-1:0] o_rdata
);

  logic [IWIDTH-1:0] r_mem [DEPTH];
  logic [IWIDTH-1:0] r_rdata;

  // Storage is not reset; contents survive m_rst.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  // Read-before-write: a capture on the write edge sees the old word.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= i_rnop ? NOP_WORD : r_mem[i_ridx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// imem_responder: slave side of the instruction fetch handshake.
//   m_clk/m_rst      clock, synchronous active-low reset
//   m_i_syn/m_i_addr fetch request strobe and byte address
//   m_i_flush        PC change, drops a request still in WAIT
//   m_o_instr        returned word (qualify with m_o_ack)
//   m_o_ack          one-cycle response strobe
//   m_o_err          misaligned / out-of-range qualifier for m_o_ack
//   m_o_busy         request outstanding (WAIT or RESP)
//   m_i_we/m_i_waddr/m_i_wdata  preload write port
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned       IWIDTH      = 32,
  parameter int unsigned       AWIDTH      = 32,
  parameter int unsigned       DEPTH       = 1024,
  parameter int unsigned       WAIT_STATES = 1,
  parameter logic [IWIDTH-1:0] NOP_WORD    = IWIDTH'(IMEM_NOP_WORD)
) (
  input  logic              m_clk,
  input  logic              m_rst,
  input  logic              m_i_syn,
  input  logic [AWIDTH-1:0] m_i_addr,
  input  logic              m_i_flush,
  output logic [IWIDTH-1:0] m_o_instr,
  output logic              m_o_ack,
  output logic              m_o_err,
  output logic              m_o_busy,
  input  logic              m_i_we,
  input  logic [AWIDTH-1:0] m_i_waddr,
  input  logic [IWIDTH-1:0] m_i_wdata
);

  localparam int unsigned IDXW = imem_idx_w(DEPTH);
  localparam int unsigned CW   = IMEM_CNT_W;

  logic [1:0]        r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [AWIDTH-1:0] r_addr, w_addr_nxt;
  logic              r_ack, r_err, r_busy;

  logic              w_accept;
  logic              w_cap;
  logic [AWIDTH-1:0] w_cap_addr;
  logic              w_cap_err;
  logic [AWIDTH-3:0] w_cap_hi;
  logic [AWIDTH-3:0] w_wr_hi;
  logic              w_wr_ok;
  logic [IWIDTH-1:0] w_rdata;
  logic              w_unused_wlsb;

  // Next-state, counter and capture decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_accept    = 1'b0;
    w_cap       = 1'b0;
    w_cap_addr  = r_addr;
    case (r_state)
      ST_IDLE: w_accept = m_i_syn;
      ST_WAIT: begin
        if (m_i_flush) begin
          w_accept    = m_i_syn;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_RESP;
          w_cap       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_RESP: begin
        w_accept    = m_i_syn;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A new request overrides whatever the current state decided.
    if (w_accept) begin
      w_addr_nxt = m_i_addr;
      if (WAIT_STATES == 0) begin
        // Zero wait states: capture straight from the incoming address.
        w_state_nxt = ST_RESP;
        w_cnt_nxt   = '0;
        w_cap       = 1'b1;
        w_cap_addr  = m_i_addr;
      end else begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = CW'(WAIT_STATES - 1);
      end
    end
  end

  // Misaligned, or word index beyond the store.
  assign w_cap_hi  = w_cap_addr[AWIDTH-1:2] >> IDXW;
  assign w_cap_err = (w_cap_addr[1:0] != 2'b00) || (w_cap_hi != '0);

  // Out-of-range preload writes are dropped; byte offset is ignored.
  assign w_wr_hi       = m_i_waddr[AWIDTH-1:2] >> IDXW;
  assign w_wr_ok       = m_i_we && (w_wr_hi == '0);
  assign w_unused_wlsb = ^m_i_waddr[1:0];

  always_ff @(posedge m_clk) begin
    if (!m_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_ack   <= w_cap;
      if (w_cap) begin
        r_err <= w_cap_err;
      end
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  imem_array #(
    .IWIDTH   (IWIDTH),
    .DEPTH    (DEPTH),
    .IDXW     (IDXW),
    .NOP_WORD (NOP_WORD)
  ) u_array (
    .i_clk   (m_clk),
    .i_rst   (m_rst),
    .i_we    (w_wr_ok),
    .i_widx  (m_i_waddr[IDXW+1:2]),
    .i_wdata (m_i_wdata),
    .i_re    (w_cap),
    .i_ridx  (w_cap_addr[IDXW+1:2]),
    .i_rnop  (w_cap_err),
    .o_rdata (w_rdata)
  );

  assign m_o_instr = w_rdata;
  assign m_o_ack   = r_ack;
  assign m_o_err   = r_err;
  assign m_o_busy  = r_busy;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (WAIT_STATES 1, 0, 3) share all
// inputs and the preloaded contents; each scenario checks the relevant one.
module tb_imem_responder;

  localparam logic [31:0] W_A0  = 32'hA0A0_A0A0;
  localparam logic [31:0] W_B1  = 32'hB1B1_B1B1;
  localparam logic [31:0] W_C2  = 32'hC2C2_C2C2;
  localparam logic [31:0] W_D3  = 32'hD3D3_D3D3;
  localparam logic [31:0] W_E4  = 32'hE4E4_E4E4;
  localparam logic [31:0] W_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        syn, flush, we;
  logic [31:0] addr, waddr, wdata;

  logic [31:0] instr1, instr0, instr3;
  logic        ack1, err1, busy1;
  logic        ack0, err0, busy0;
  logic        ack3, err3, busy3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_responder #(.WAIT_STATES(1)) u_ws1 (
    .m_clk(clk), .m_rst(rst_n), .m_i_syn(syn), .m_i_addr(addr), .m_i_flush(flush),
    .m_o_instr(instr1), .m_o_ack(ack1), .m_o_err(err1), .m_o_busy(busy1),
    .m_i_we(we), .m_i_waddr(waddr), .m_i_wdata(wdata));

  imem_responder #(.WAIT_STATES(0)) u_ws0 (
    .m_clk(clk), .m_rst(rst_n), .m_i_syn(syn), .m_i_addr(addr), .m_i_flush(flush),
    .m_o_instr(instr0), .m_o_ack(ack0), .m_o_err(err0), .m_o_busy(busy0),
    .m_i_we(we), .m_i_waddr(waddr), .m_i_wdata(wdata));

  imem_responder #(.WAIT_STATES(3)) u_ws3 (
    .m_clk(clk), .m_rst(rst_n), .m_i_syn(syn), .m_i_addr(addr), .m_i_flush(flush),
    .m_o_instr(instr3), .m_o_ack(ack3), .m_o_err(err3), .m_o_busy(busy3),
    .m_i_we(we), .m_i_waddr(waddr), .m_i_wdata(wdata));

  typedef struct {
    logic        syn;
    logic [31:0] addr;
    logic        flush;
    logic        ack;
    logic        err;
    logic        busy;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic s, input logic [31:0] a, input logic f,
                              input logic k, input logic e, input logic b,
                              input logic [31:0] d);
    vec_t v;
    v.syn = s; v.addr = a; v.flush = f; v.ack = k; v.err = e; v.busy = b; v.instr = d;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic idle(input int n);
    syn = 1'b0; flush = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // With wait states, ack must never be high on two consecutive cycles.
  logic prev1 = 1'b0, prev3 = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ((ack1 && prev1) || (ack3 && prev3)) begin
        failures++;
        $display("FAIL ack_consecutive: ws1 %b%b ws3 %b%b required no back-to-back ack",
                 prev1, ack1, prev3, ack3);
      end
    end
    prev1 = ack1;
    prev3 = ack3;
  end

  initial begin
    rst_n = 1'b0; syn = 1'b0; flush = 1'b0; we = 1'b0;
    addr = '0; waddr = '0; wdata = '0;

    // Vectors for the WAIT_STATES=1 instance: inputs before the edge,
    // expected registered outputs after it. err/instr checked only with ack.
    vecs[0]  = mk(1, 32'h0,    0, 0, 0, 1, 32'h0);
    vecs[1]  = mk(0, 32'h0,    0, 1, 0, 1, W_A0);
    vecs[2]  = mk(0, 32'h0,    0, 0, 0, 0, 32'h0);
    vecs[3]  = mk(1, 32'h4,    0, 0, 0, 1, 32'h0);
    vecs[4]  = mk(0, 32'h0,    0, 1, 0, 1, W_B1);
    vecs[5]  = mk(1, 32'h8,    0, 0, 0, 1, 32'h0);  // issued during RESP
    vecs[6]  = mk(0, 32'h0,    0, 1, 0, 1, W_C2);
    vecs[7]  = mk(0, 32'h0,    0, 0, 0, 0, 32'h0);
    vecs[8]  = mk(1, 32'h4,    0, 0, 0, 1, 32'h0);
    vecs[9]  = mk(0, 32'h0,    1, 0, 0, 0, 32'h0);  // flush in WAIT
    vecs[10] = mk(0, 32'h0,    0, 0, 0, 0, 32'h0);
    vecs[11] = mk(1, 32'h100,  0, 0, 0, 1, 32'h0);
    vecs[12] = mk(0, 32'h0,    0, 1, 0, 1, W_D3);
    vecs[13] = mk(0, 32'h0,    0, 0, 0, 0, 32'h0);
    vecs[14] = mk(1, 32'h2,    0, 0, 0, 1, 32'h0);  // misaligned
    vecs[15] = mk(0, 32'h0,    0, 1, 1, 1, W_NOP);
    vecs[16] = mk(1, 32'h1000, 0, 0, 0, 1, 32'h0);  // out of range
    vecs[17] = mk(0, 32'h0,    0, 1, 1, 1, W_NOP);
    vecs[18] = mk(0, 32'h0,    0, 0, 0, 0, 32'h0);
    vecs[19] = mk(1, 32'h0,    0, 0, 0, 1, 32'h0);
    vecs[20] = mk(1, 32'h8,    1, 0, 0, 1, 32'h0);  // flush+syn retargets
    vecs[21] = mk(0, 32'h0,    0, 1, 0, 1, W_C2);
    vecs[22] = mk(0, 32'h0,    0, 0, 0, 0, 32'h0);

    // Reset held two cycles.
    tick(); tick();
    chk("rst_ack",   32'(ack1),  32'h0);
    chk("rst_err",   32'(err1),  32'h0);
    chk("rst_instr", instr1,     32'h0);
    chk("rst_busy",  32'(busy1), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ack",  32'(ack1),  32'h0);
    chk("post_rst_busy", 32'(busy1), 32'h0);

    preload(32'h0,   W_A0);
    preload(32'h4,   W_B1);
    preload(32'h8,   W_C2);
    preload(32'h100, W_D3);
    preload(32'h4000, 32'hDEAD_BEEF);  // out of range, must be dropped

    for (int i = 0; i < 23; i++) begin
      syn = vecs[i].syn; addr = vecs[i].addr; flush = vecs[i].flush;
      tick();
      chk($sformatf("vec%0d_ack", i),  32'(ack1),  32'(vecs[i].ack));
      chk($sformatf("vec%0d_busy", i), 32'(busy1), 32'(vecs[i].busy));
      if (vecs[i].ack) begin
        chk($sformatf("vec%0d_err", i),   32'(err1), 32'(vecs[i].err));
        chk($sformatf("vec%0d_instr", i), instr1,    vecs[i].instr);
      end
    end
    idle(5);

    // Zero wait states, syn held: ack every cycle.
    syn = 1'b1; addr = 32'h0; tick();
    chk("b2b0_ack", 32'(ack0), 32'h1); chk("b2b0_instr", instr0, W_A0);
    addr = 32'h4; tick();
    chk("b2b1_ack", 32'(ack0), 32'h1); chk("b2b1_instr", instr0, W_B1);
    addr = 32'h8; tick();
    chk("b2b2_ack", 32'(ack0), 32'h1); chk("b2b2_instr", instr0, W_C2);
    chk("b2b2_err", 32'(err0), 32'h0);
    syn = 1'b0; tick();
    chk("b2b_end_ack",  32'(ack0),  32'h0);
    chk("b2b_end_busy", 32'(busy0), 32'h0);
    idle(5);

    // Reset one cycle after accept in WAIT_STATES=3: silent abort.
    syn = 1'b1; addr = 32'h4; tick();
    chk("rstw_busy_acc", 32'(busy3), 32'h1);
    syn = 1'b0; rst_n = 1'b0; tick();
    chk("rstw_ack",   32'(ack3),  32'h0);
    chk("rstw_busy",  32'(busy3), 32'h0);
    chk("rstw_instr", instr3,     32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rstw_noack%0d", k), 32'(ack3), 32'h0);
    end
    chk("rstw_idle_busy", 32'(busy3), 32'h0);

    // Same-edge write and capture of word 0: old word first, new word next.
    syn = 1'b1; addr = 32'h0; we = 1'b1; waddr = 32'h0; wdata = W_E4; tick();
    chk("rw_old_ack",   32'(ack0), 32'h1);
    chk("rw_old_instr", instr0,    W_A0);
    we = 1'b0; tick();
    chk("rw_new_ack0",   32'(ack0), 32'h1);
    chk("rw_new_instr0", instr0,    W_E4);
    chk("rw_new_ack1",   32'(ack1), 32'h1);
    chk("rw_new_instr1", instr1,    W_E4);
    chk("ws3_lat_b",     32'(ack3), 32'h0);
    syn = 1'b0; tick();
    chk("ws3_lat_c",     32'(ack3), 32'h0);
    tick();
    chk("ws3_lat_ack",   32'(ack3), 32'h1);
    chk("ws3_lat_instr", instr3,    W_E4);
    chk("ws3_lat_err",   32'(err3), 32'h0);
    tick();
    chk("ws3_after_ack",  32'(ack3),  32'h0);
    chk("ws3_after_busy", 32'(busy3), 32'h0);
    chk("ws3_hold_instr", instr3,     W_E4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder: the slave end of the fetch request/acknowledge handshake. It accepts a fetch address qualified by a request strobe and returns the addressed instruction word with a single-cycle acknowledge after a configurable number of wait states. It supports abort on a PC change and a side write port for program preload. It sits between the instruction-fetch stage and the on-chip instruction store.

## Interface
- IWIDTH, 32: instruction word width.
- AWIDTH, 32: byte-address width.
- DEPTH, 1024: number of IWIDTH words stored; power of two.
- WAIT_STATES, 1: extra cycles between request accept and ack; 0..15.
- NOP_WORD, 32'h0000_0013: word returned on an erroneous access.
- m_clk  in  1  clock; all state updates on the rising edge.
- m_rst  in  1  synchronous, active-low reset.
- m_i_syn  in  1  fetch request strobe from the fetch stage.
- m_i_addr  in  AWIDTH  byte address of the requested instruction.
- m_i_flush  in  1  PC change; abort any outstanding request.
- m_o_instr  out  IWIDTH  returned instruction; valid only while m_o_ack=1.
- m_o_ack  out  1  one-cycle response strobe.
- m_o_err  out  1  qualifies m_o_ack: misaligned or out-of-range access.
- m_o_busy  out  1  request outstanding (state WAIT or RESP).
- m_i_we  in  1  preload write enable.
- m_i_waddr  in  AWIDTH  preload byte address; word index = waddr[AWIDTH-1:2].
- m_i_wdata  in  IWIDTH  preload data.

## Operation
- Word index = addr[AWIDTH-1:2]. Error conditions: addr[1:0]!=0, or index>=DEPTH.
- FSM states: IDLE, WAIT, RESP.
- IDLE: when m_i_syn=1, latch the address.
  - WAIT_STATES=0: go to RESP.
  - Otherwise: load the counter with WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the counter; when it is 0, go to RESP.
  - m_i_flush=1 in WAIT: drop the request. Go to IDLE, or accept a new request if m_i_syn=1 in the same cycle.
- On entry to RESP, register the outputs:
  - m_o_ack=1.
  - m_o_instr = mem[index], or NOP_WORD on error.
  - m_o_err = error.
- RESP lasts one cycle and m_o_ack drops afterwards.
  - m_i_syn=1 during RESP is accepted as the next request (same rule as IDLE), so the requester can issue back to back.
  - m_i_flush during RESP does not suppress the ack already driven; the fetch stage discards it.
- Flush and syn together in IDLE or RESP: syn is accepted (new target address).
- Preload writes: m_i_we writes mem[windex] on the clock edge, in any state. Out-of-range writes are ignored.
  - A write and a response capture to the same word on the same edge: the response returns the old data.
- Memory contents are not affected by reset. The array is uninitialised in simulation unless preloaded.

## Timing
- Reset (m_rst=0 at the edge):
  - State goes to IDLE and the counter to 0.
  - m_o_ack=0, m_o_err=0, m_o_instr=0, m_o_busy=0.
  - Reset in the middle of WAIT aborts silently, with no ack.
- Latency: syn sampled at edge N → m_o_ack high during cycle N+WAIT_STATES+1.
- Throughput: one response per WAIT_STATES+1 cycles.
- m_o_ack is never high for two consecutive cycles when WAIT_STATES>0. With WAIT_STATES=0 and syn held high, it pulses every cycle.
- m_o_busy is registered: high from the edge after accept until the edge after RESP (unless a new request is accepted there).
- m_o_instr and m_o_err hold their last value when ack=0. Consumers must qualify them with ack.

## Structure
- Shared package imem_pkg:
  - State encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - NOP_WORD constant.
  - Word-index helper width, $clog2(DEPTH).
- Sub-module imem_array: a DEPTH×IWIDTH single write port, with a synchronous read registered on the response-capture edge.
- FSM, counter and error check live in imem_responder.

## Test plan
- Reset held 2 cycles, then released: ack=0, err=0, instr=0, busy=0. Preload mem[0..2] = A0A0A0A0, B1B1B1B1, C2C2C2C2.
- WAIT_STATES=1:
  - Stimulus: syn pulse with addr 0x0, then 0x4, then 0x8.
  - Required: ack 2 cycles after each syn, returning A0A0A0A0, B1B1B1B1, C2C2C2C2 with err=0.
- Flush abort:
  - Stimulus: syn addr 0x4, then flush in the next cycle (in WAIT).
  - Required: no ack, busy=0 afterwards.
  - Then syn addr 0x100 with mem[64]=D3D3D3D3 preloaded → ack with D3D3D3D3.
- Errors:
  - syn addr 0x2 → ack, err=1, instr=00000013.
  - syn addr 0x1000 with DEPTH=1024 → ack, err=1, instr=00000013.
- Back-to-back: WAIT_STATES=0 and syn held high for addrs 0x0, 0x4, 0x8 → ack high for 3 consecutive cycles carrying A0A0A0A0, B1B1B1B1, C2C2C2C2.
- Reset mid-WAIT (WAIT_STATES=3): m_rst=0 one cycle after accept → no ack ever, state IDLE. Same-edge write to 0x0 (E4E4E4E4) during a capture of 0x0 → old word returned, and the next read returns E4E4E4E4.
